// File: rtl/board_state_keeper.sv
// Board store and move checker for the 3x3 game: validates one move request per turn,
// records accepted marks, and flags win/tie for the downstream game controller.
module board_state_keeper (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        clear_i,
    input  logic        req_i,
    input  logic [3:0]  req_pos_i,
    input  logic        player_i,
    output logic        ready_o,
    output logic        v_o,
    output logic        invalid_o,
    output logic        win_o,
    output logic        tie_o,
    output logic        winner_o,
    output logic [17:0] board_o,
    output logic [3:0]  move_count_o
);

    // state  | meaning
    // S_IDLE | waiting for a move request; requests are evaluated here
    // S_EVAL | move just written; line check runs on the updated board
    // S_DONE | game over (win or tie); every request is rejected
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EVAL = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [17:0] board_q, board_d;
    logic [3:0]  count_q, count_d;
    logic        player_q, player_d;
    logic        v_q, v_d;
    logic        invalid_q, invalid_d;
    logic        win_q, win_d;
    logic        tie_q, tie_d;
    logic        winner_q, winner_d;

    logic [1:0]  mark_lat;
    logic [1:0]  mark_req;
    logic [8:0]  own;
    logic        line_hit;
    logic        pos_ok;
    logic        cell_free;

    assign mark_lat = player_q ? 2'b10 : 2'b01;
    assign mark_req = player_i ? 2'b10 : 2'b01;
    assign pos_ok   = (req_pos_i <= 4'd8);

    always_comb begin
        own = '0;
        for (int i = 0; i < 9; i++) begin
            own[i] = (board_q[2*i +: 2] == mark_lat);
        end
    end

    assign line_hit = (own[0] & own[1] & own[2]) |
                      (own[3] & own[4] & own[5]) |
                      (own[6] & own[7] & own[8]) |
                      (own[0] & own[3] & own[6]) |
                      (own[1] & own[4] & own[7]) |
                      (own[2] & own[5] & own[8]) |
                      (own[0] & own[4] & own[8]) |
                      (own[2] & own[4] & own[6]);

    // Positions 9..15 match no cell, so cell_free stays 0 and pos_ok rejects them anyway.
    always_comb begin
        cell_free = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (req_pos_i == 4'(i)) begin
                cell_free = (board_q[2*i +: 2] == 2'b00);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        board_d   = board_q;
        count_d   = count_q;
        player_d  = player_q;
        v_d       = 1'b0;
        invalid_d = 1'b0;
        win_d     = win_q;
        tie_d     = tie_q;
        winner_d  = winner_q;

        if (clear_i) begin
            state_d  = S_IDLE;
            board_d  = '0;
            count_d  = '0;
            player_d = 1'b0;
            win_d    = 1'b0;
            tie_d    = 1'b0;
            winner_d = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (req_i) begin
                        if (!pos_ok || !cell_free) begin
                            invalid_d = 1'b1;
                        end else begin
                            for (int i = 0; i < 9; i++) begin
                                if (req_pos_i == 4'(i)) begin
                                    board_d[2*i +: 2] = mark_req;
                                end
                            end
                            count_d  = count_q + 4'd1;
                            player_d = player_i;
                            state_d  = S_EVAL;
                        end
                    end
                end
                S_EVAL: begin
                    v_d = 1'b1;
                    if (line_hit) begin
                        win_d    = 1'b1;
                        winner_d = player_q;
                        state_d  = S_DONE;
                    end else if (count_q == 4'd9) begin
                        tie_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_DONE: begin
                    if (req_i) begin
                        invalid_d = 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= S_IDLE;
            board_q   <= '0;
            count_q   <= '0;
            player_q  <= 1'b0;
            v_q       <= 1'b0;
            invalid_q <= 1'b0;
            win_q     <= 1'b0;
            tie_q     <= 1'b0;
            winner_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            board_q   <= board_d;
            count_q   <= count_d;
            player_q  <= player_d;
            v_q       <= v_d;
            invalid_q <= invalid_d;
            win_q     <= win_d;
            tie_q     <= tie_d;
            winner_q  <= winner_d;
        end
    end

    assign ready_o      = (state_q == S_IDLE);
    assign v_o          = v_q;
    assign invalid_o    = invalid_q;
    assign win_o        = win_q;
    assign tie_o        = tie_q;
    assign winner_o     = winner_q;
    assign board_o      = board_q;
    assign move_count_o = count_q;

endmodule

// File: tb/tb_board_state_keeper.sv
// Bench for board_state_keeper: directed game scenarios plus random games checked
// against a cell-array model of the game rules.
module tb_board_state_keeper;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        req = 1'b0;
    logic [3:0]  req_pos = 4'd0;
    logic        player = 1'b0;
    logic        ready, v, invalid, win, tie, winner;
    logic [17:0] board;
    logic [3:0]  move_count;

    int checks = 0;
    int errors = 0;

    int cells [9];
    int m_count;
    bit m_win, m_tie, m_winner;

    int lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                         '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

    always #5 clk = ~clk;

    board_state_keeper dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .clear_i      (clear),
        .req_i        (req),
        .req_pos_i    (req_pos),
        .player_i     (player),
        .ready_o      (ready),
        .v_o          (v),
        .invalid_o    (invalid),
        .win_o        (win),
        .tie_o        (tie),
        .winner_o     (winner),
        .board_o      (board),
        .move_count_o (move_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [17:0] m_board();
        logic [17:0] b;
        b = '0;
        for (int i = 0; i < 9; i++) b = b | (18'(cells[i]) << (2 * i));
        return b;
    endfunction

    function automatic bit m_line(input int mark);
        for (int l = 0; l < 8; l++)
            if (cells[lines[l][0]] == mark && cells[lines[l][1]] == mark && cells[lines[l][2]] == mark)
                return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_done();
        return m_win || m_tie;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 9; i++) cells[i] = 0;
        m_count = 0;
        m_win = 0;
        m_tie = 0;
        m_winner = 0;
    endtask

    task automatic check_outputs(input string tag, input bit exp_v, input bit exp_inv, input bit exp_ready);
        chk({tag, "/V"}, 32'(v), 32'(exp_v));
        chk({tag, "/invalid"}, 32'(invalid), 32'(exp_inv));
        chk({tag, "/Ready"}, 32'(ready), 32'(exp_ready));
        chk({tag, "/board"}, 32'(board), 32'(m_board()));
        chk({tag, "/count"}, 32'(move_count), 32'(m_count));
        chk({tag, "/Win"}, 32'(win), 32'(m_win));
        chk({tag, "/Tie"}, 32'(tie), 32'(m_tie));
        if (m_win) chk({tag, "/winner"}, 32'(winner), 32'(m_winner));
    endtask

    // Called at a falling edge; returns at a falling edge ready for the next request.
    task automatic move(input int pos, input bit pl);
        bit accept;
        accept = 1'b0;
        if (!m_done() && pos >= 0 && pos <= 8) accept = (cells[pos] == 0);
        req = 1'b1;
        req_pos = 4'(pos);
        player = pl;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        if (accept) begin
            cells[pos] = pl ? 2 : 1;
            m_count++;
            check_outputs("accept_written", 1'b0, 1'b0, 1'b0);
            if (m_line(pl ? 2 : 1)) begin
                m_win = 1'b1;
                m_winner = pl;
            end else if (m_count == 9) begin
                m_tie = 1'b1;
            end
            @(negedge clk);
            check_outputs("accept_eval", 1'b1, 1'b0, !m_done());
        end else begin
            check_outputs("reject", 1'b0, 1'b1, !m_done());
        end
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        check_outputs("idle", 1'b0, 1'b0, !m_done());
    endtask

    task automatic clear_board();
        clear = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clear = 1'b0;
        m_reset();
        check_outputs("clear", 1'b0, 1'b0, 1'b1);
    endtask

    task automatic play(input int seq [9]);
        for (int i = 0; i < 9; i++) move(seq[i], 1'(i % 2));
    endtask

    initial begin
        int pos;
        bit pl;
        int extra;

        m_reset();
        #1;
        check_outputs("in_reset", 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_outputs("after_reset", 1'b0, 1'b0, 1'b1);

        // X takes the top row
        move(0, 0); move(4, 1); move(1, 0); move(8, 1); move(2, 0);
        chk("toprow/board_const", 32'(board), 32'h20215);
        chk("toprow/win_const", 32'(win), 32'd1);
        move(5, 1);
        idle_cycle();

        // Occupied cell and out-of-range positions
        clear_board();
        move(4, 0);
        move(4, 1);
        move(9, 1);
        move(15, 0);
        idle_cycle();

        clear_board();
        play('{0, 1, 2, 4, 3, 5, 7, 6, 8});
        chk("tie/tie_const", 32'(tie), 32'd1);
        move(6, 0);

        clear_board();
        play('{0, 1, 2, 4, 3, 5, 7, 8, 6});
        chk("win9/win_const", 32'(win), 32'd1);
        chk("win9/tie_const", 32'(tie), 32'd0);

        // clear together with a request: clear wins, request gets no response
        clear_board();
        move(0, 0);
        req = 1'b1; req_pos = 4'd5; player = 1'b1; clear = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0; clear = 1'b0;
        m_reset();
        check_outputs("clear_req", 1'b0, 1'b0, 1'b1);
        idle_cycle();

        // request while the previous move is being evaluated is dropped
        req = 1'b1; req_pos = 4'd0; player = 1'b0;
        @(posedge clk);
        @(negedge clk);
        cells[0] = 1; m_count = 1;
        check_outputs("eval_req_first", 1'b0, 1'b0, 1'b0);
        req_pos = 4'd1; player = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        check_outputs("eval_req_dropped", 1'b1, 1'b0, 1'b1);
        idle_cycle();

        // reset asserted while the accepted move is in evaluation
        req = 1'b1; req_pos = 4'd3; player = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        cells[3] = 2; m_count = 2;
        check_outputs("pre_rst", 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        m_reset();
        check_outputs("rst_in_eval", 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        check_outputs("rst_held", 1'b0, 1'b0, 1'b1);
        rst_n = 1'b1;
        idle_cycle();
        idle_cycle();

        // random games
        for (int g = 0; g < 30; g++) begin
            clear_board();
            pl = 1'($urandom_range(0, 1));
            extra = 0;
            for (int k = 0; k < 30 && extra < 3; k++) begin
                if ($urandom_range(0, 4) == 0) pos = $urandom_range(9, 15);
                else pos = $urandom_range(0, 8);
                if ($urandom_range(0, 5) == 0) pl = 1'($urandom_range(0, 1));
                move(pos, pl);
                pl = ~pl;
                if (m_done()) extra++;
            end
            idle_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
